// File: rtl/snake_pkg.sv
// Shared definitions for the snake move scheduler: direction codes,
// game-state encoding and direction helper functions.
// Pure package: no logic, no latency, no flow control.
package snake_pkg;

    localparam int DIR_W = 6;

    localparam logic [DIR_W-1:0] DIR_LEFT  = 6'b000001;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 6'b000010;
    localparam logic [DIR_W-1:0] DIR_UP    = 6'b000100;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 6'b001000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DEAD  = 2'b11
    } state_t;

    // True only for the four single-direction codes; zero and multi-hot are rejected.
    function automatic logic is_legal_dir(input logic [DIR_W-1:0] d);
        return (d == DIR_LEFT) || (d == DIR_RIGHT) || (d == DIR_UP) || (d == DIR_DOWN);
    endfunction

    // True when a and b point in exactly opposite directions.
    function automatic logic is_opposite(input logic [DIR_W-1:0] a, input logic [DIR_W-1:0] b);
        return ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
               ((a == DIR_RIGHT) && (b == DIR_LEFT))  ||
               ((a == DIR_UP)    && (b == DIR_DOWN))  ||
               ((a == DIR_DOWN)  && (b == DIR_UP));
    endfunction

endpackage

// File: rtl/turn_fifo.sv
// Two-entry pending-turn FIFO; head/tail/count reflect registered contents.
// Latency: push visible at head/tail one cycle later; simultaneous push+pop keeps count.
// Backpressure: none; caller must not push when full or pop when empty (such requests are dropped).
// Ports: clk, reset (sync, active-high), push, pop, flush, din -> head, tail, count.
module turn_fifo
    import snake_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [DIR_W-1:0] din,
    output logic [DIR_W-1:0] head,
    output logic [DIR_W-1:0] tail,
    output logic [1:0]       count
);

    logic [DIR_W-1:0] e0;   // oldest entry
    logic [DIR_W-1:0] e1;   // second entry, valid only when count == 2

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count <= 2'd0;
            e0    <= '0;
            e1    <= '0;
        end else if (push && pop && (count != 2'd0)) begin
            // Pop the old head and append din in one edge.
            if (count == 2'd2) begin
                e0 <= e1;
                e1 <= din;
            end else begin
                e0 <= din;
            end
        end else if (push) begin
            if (count == 2'd0) begin
                e0    <= din;
                count <= 2'd1;
            end else if (count == 2'd1) begin
                e1    <= din;
                count <= 2'd2;
            end
        end else if (pop && (count != 2'd0)) begin
            e0    <= e1;
            count <= count - 2'd1;
        end
    end

    assign head = e0;
    assign tail = (count == 2'd2) ? e1 : e0;

endmodule

// File: rtl/snake_move_scheduler.sv
// Game FSM, move tick generator and turn filter feeding a 2-deep turn queue.
// Latency: step and the popped dir_out appear together, one registered edge after the counter hits TICK_DIV-1.
// Backpressure: none; turn requests arriving while the queue is full are dropped.
// Ports: clk, reset (sync, active-high), dir_in, start, pause_btn, collision -> step, dir_out, state, q_count.
module snake_move_scheduler
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 2500000,
    parameter int QDEPTH   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIR_W-1:0] dir_in,
    input  logic             start,
    input  logic             pause_btn,
    input  logic             collision,
    output logic             step,
    output logic [DIR_W-1:0] dir_out,
    output logic [1:0]       state,
    output logic [1:0]       q_count
);

    localparam int            CW        = $clog2(TICK_DIV);
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

    state_t           st;
    logic [CW-1:0]    cnt;
    logic [DIR_W-1:0] dir_prev;
    logic             pause_prev;

    logic [DIR_W-1:0] q_head;
    logic [DIR_W-1:0] q_tail;
    logic [DIR_W-1:0] ref_dir;
    logic             new_req;
    logic             pause_rise;
    logic             tick_fire;
    logic             q_push;
    logic             q_pop;
    logic             q_flush;

    assign new_req    = (dir_in != dir_prev) && is_legal_dir(dir_in);
    assign pause_rise = pause_btn && !pause_prev;

    // A turn is compared against the last queued turn, or the live heading if none is queued.
    assign ref_dir = (q_count != 2'd0) ? q_tail : dir_out;

    // Collision and pause both pre-empt the tick on the same edge.
    assign tick_fire = (st == ST_RUN) && !collision && !pause_rise && (cnt == TICK_LAST);

    assign q_push  = (st == ST_RUN) && new_req && (q_count != 2'(QDEPTH)) &&
                     (dir_in != ref_dir) && !is_opposite(dir_in, ref_dir);
    assign q_pop   = tick_fire && (q_count != 2'd0);
    assign q_flush = (st == ST_DEAD) && start;

    turn_fifo u_turn_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .flush (q_flush),
        .din   (dir_in),
        .head  (q_head),
        .tail  (q_tail),
        .count (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= ST_IDLE;
            cnt        <= '0;
            step       <= 1'b0;
            dir_out    <= DIR_RIGHT;
            dir_prev   <= '0;
            pause_prev <= 1'b0;
        end else begin
            dir_prev   <= dir_in;
            pause_prev <= pause_btn;
            step       <= 1'b0;
            unique case (st)
                ST_IDLE: begin
                    if (start) begin
                        st  <= ST_RUN;
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (collision) begin
                        st <= ST_DEAD;
                    end else if (pause_rise) begin
                        st <= ST_PAUSE;
                    end else if (tick_fire) begin
                        cnt  <= '0;
                        step <= 1'b1;
                        if (q_pop) begin
                            dir_out <= q_head;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    // Counter is frozen here so the run resumes mid-period.
                    if (pause_rise) begin
                        st <= ST_RUN;
                    end
                end
                ST_DEAD: begin
                    if (start) begin
                        st      <= ST_IDLE;
                        cnt     <= '0;
                        dir_out <= DIR_RIGHT;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign state = st;

endmodule
